// File: rtl/muldiv_if.sv
// Pipeline- and sub-unit-facing signals of the multiply/divide sequencer.
// slave = the sequencer, master = the EX stage plus the multiplier/divider cores.
interface muldiv_if #(parameter int DATA_W = 32);
  logic                  op_valid;
  logic [2:0]            op_code;
  logic [DATA_W-1:0]     rs_val;
  logic [DATA_W-1:0]     rt_val;
  logic                  rd_req;
  logic                  rd_sel;
  logic [DATA_W-1:0]     rd_data;
  logic                  stall;
  logic                  busy;
  logic                  err;
  logic                  mul_start;
  logic [DATA_W-1:0]     mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_product;
  logic                  div_start;
  logic [DATA_W-1:0]     div_dividend;
  logic [DATA_W-1:0]     div_divisor;
  logic                  div_done;
  logic [DATA_W-1:0]     div_quot;
  logic [DATA_W-1:0]     div_rem;

  modport slave (
    input  op_valid, op_code, rs_val, rt_val, rd_req, rd_sel,
           mul_done, mul_product, div_done, div_quot, div_rem,
    output rd_data, stall, busy, err, mul_start, mul_a, mul_b,
           div_start, div_dividend, div_divisor
  );

  modport master (
    output op_valid, op_code, rs_val, rt_val, rd_req, rd_sel,
           mul_done, mul_product, div_done, div_quot, div_rem,
    input  rd_data, stall, busy, err, mul_start, mul_a, mul_b,
           div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// MIPS mult/div sequencer: owns HI/LO, drives the signed multiplier and unsigned divider.
// Optional HILO_FWD_EN: forward the fixed-up result to rd_data during FIX instead of stalling.
module muldiv_ctrl #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 40
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);
  localparam int MSB = DATA_W - 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, FIX} state_t;

  state_t            state;
  logic [2:0]        op_r;
  logic [DATA_W-1:0] a_r, b_r, hi, lo, raw_hi, raw_lo, dvd_r, dvs_r;
  logic [DATA_W-1:0] fix_hi, fix_lo;
  logic              dz_r, err_r, mul_start_r, div_start_r;
  logic [CW-1:0]     cnt;
  logic              timeout;

  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1));

  // Raw results are latched on done; sign/unsigned correction happens here in FIX.
  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    if (dz_r) begin
      fix_lo = '1;
      fix_hi = a_r;
    end else begin
      case (op_r)
        OP_MULTU: fix_hi = raw_hi + (a_r[MSB] ? b_r : '0) + (b_r[MSB] ? a_r : '0);
        OP_DIV: begin
          if (a_r[MSB] ^ b_r[MSB]) fix_lo = -raw_lo;
          if (a_r[MSB])            fix_hi = -raw_hi;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      hi          <= '0;
      lo          <= '0;
      raw_hi      <= '0;
      raw_lo      <= '0;
      dz_r        <= 1'b0;
      err_r       <= 1'b0;
      mul_start_r <= 1'b0;
      div_start_r <= 1'b0;
      cnt         <= '0;
    end else begin
      mul_start_r <= 1'b0;
      div_start_r <= 1'b0;
      case (state)
        IDLE: if (bus.op_valid) begin
          err_r <= 1'b0;
          op_r  <= bus.op_code;
          a_r   <= bus.rs_val;
          b_r   <= bus.rt_val;
          dz_r  <= 1'b0;
          cnt   <= '0;
          case (bus.op_code)
            OP_MULT, OP_MULTU: begin
              mul_start_r <= 1'b1;
              state       <= MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.rt_val == '0) begin
                dz_r  <= 1'b1;
                state <= FIX;
              end else begin
                dvd_r <= (bus.op_code == OP_DIV && bus.rs_val[MSB]) ? -bus.rs_val : bus.rs_val;
                dvs_r <= (bus.op_code == OP_DIV && bus.rt_val[MSB]) ? -bus.rt_val : bus.rt_val;
                div_start_r <= 1'b1;
                state       <= DIV_WAIT;
              end
            end
            OP_MTHI: hi <= bus.rs_val;
            OP_MTLO: lo <= bus.rs_val;
            default: ;
          endcase
        end
        MUL_WAIT: begin
          if (bus.mul_done) begin
            raw_hi <= bus.mul_product[2*DATA_W-1:DATA_W];
            raw_lo <= bus.mul_product[DATA_W-1:0];
            state  <= FIX;
          end else if (timeout) begin
            err_r <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_WAIT: begin
          if (bus.div_done) begin
            raw_hi <= bus.div_rem;
            raw_lo <= bus.div_quot;
            state  <= FIX;
          end else if (timeout) begin
            err_r <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.err          = err_r;
  assign bus.mul_start    = mul_start_r;
  assign bus.mul_a        = a_r;
  assign bus.mul_b        = b_r;
  assign bus.div_start    = div_start_r;
  assign bus.div_dividend = dvd_r;
  assign bus.div_divisor  = dvs_r;

`ifdef HILO_FWD_EN
  assign bus.stall   = bus.busy & (bus.op_valid | (bus.rd_req & (state != FIX)));
  assign bus.rd_data = (state == FIX) ? (bus.rd_sel ? fix_hi : fix_lo)
                                      : (bus.rd_sel ? hi : lo);
`else
  assign bus.stall   = bus.busy & (bus.op_valid | bus.rd_req);
  assign bus.rd_data = bus.rd_sel ? hi : lo;
`endif
endmodule
